// File: rtl/lfsr_encrypt_engine.sv
// lfsr_encrypt_engine
// Data-memory master that turns a plaintext message in DM[0..60] into 64
// cipher bytes in DM[64..127]. The message is shifted right by pre_length
// spaces, padded with spaces, XORed with a 7-bit LFSR keystream and given an
// even-parity bit in bit 7. The memory read port is combinational, so each
// load state presents its address and latches mem_rdata on the same edge.

module lfsr_encrypt_engine #(
   parameter int         MSG_BASE  = 0,
   parameter int         MSG_MAX   = 61,
   parameter int         PRE_ADDR  = 61,
   parameter int         TAP_ADDR  = 62,
   parameter int         SEED_ADDR = 63,
   parameter int         OUT_BASE  = 64,
   parameter int         OUT_LEN   = 64,
   parameter logic [7:0] PAD_CHAR  = 8'h20
) (
   input  logic       clk,
   input  logic       init,
   input  logic       req,
   output logic       ack,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rdata,
   output logic [7:0] mem_wdata,
   output logic       mem_we
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LD_PRE  = 3'd1;
   localparam logic [2:0] S_LD_TAP  = 3'd2;
   localparam logic [2:0] S_LD_SEED = 3'd3;
   localparam logic [2:0] S_ENC_RD  = 3'd4;
   localparam logic [2:0] S_ENC_WR  = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   localparam logic [7:0] L_MSG_BASE  = 8'(MSG_BASE);
   localparam logic [7:0] L_PRE_ADDR  = 8'(PRE_ADDR);
   localparam logic [7:0] L_TAP_ADDR  = 8'(TAP_ADDR);
   localparam logic [7:0] L_SEED_ADDR = 8'(SEED_ADDR);
   localparam logic [7:0] L_OUT_BASE  = 8'(OUT_BASE);
   localparam logic [6:0] L_MSG_MAX   = 7'(MSG_MAX);
   localparam logic [6:0] L_LAST_IDX  = 7'(OUT_LEN - 1);

   logic [2:0] r_state;
   logic [6:0] r_i;       // output byte index
   logic [3:0] r_pre;     // number of leading spaces
   logic [6:0] r_taps;
   logic [6:0] r_lfsr;
   logic [7:0] r_c;       // cipher byte latched in ENC_RD, written in ENC_WR

   logic       w_in_pre;
   logic [6:0] w_k;
   logic       w_msg_valid;
   logic [7:0] w_plain;
   logic [7:0] w_cipher;
   logic [6:0] w_lfsr_next;
   logic [6:0] w_seed;

   // Position inside the padded message. w_k is only meaningful outside the
   // leading-space window; pre values past the message simply push k out of
   // range, so no clamp is needed.
   assign w_in_pre    = (r_i < {3'b000, r_pre});
   assign w_k         = r_i - {3'b000, r_pre};
   assign w_msg_valid = !w_in_pre && (w_k < L_MSG_MAX);

   // Plaintext bit 7 is dropped; with bit 7 forced to zero, the parity of the
   // full byte equals the parity of the seven data bits.
   assign w_plain     = (w_msg_valid ? mem_rdata : PAD_CHAR) & 8'h7F;
   assign w_cipher    = w_plain ^ {1'b0, r_lfsr};
   assign w_lfsr_next = {r_lfsr[5:0], ^(r_lfsr & r_taps)};
   assign w_seed      = (mem_rdata[6:0] == 7'h00) ? 7'h01 : mem_rdata[6:0];

   assign ack       = (r_state == S_DONE);
   assign mem_we    = (r_state == S_ENC_WR);
   assign mem_wdata = (r_state == S_ENC_WR) ? r_c : 8'h00;

   // Address decode: pure function of state and index so reads return data
   // in the same cycle they are issued.
   always_comb begin
      mem_addr = 8'h00;
      case (r_state)
         S_LD_PRE:  mem_addr = L_PRE_ADDR;
         S_LD_TAP:  mem_addr = L_TAP_ADDR;
         S_LD_SEED: mem_addr = L_SEED_ADDR;
         S_ENC_RD:  mem_addr = w_msg_valid ? (L_MSG_BASE + {1'b0, w_k}) : L_MSG_BASE;
         S_ENC_WR:  mem_addr = L_OUT_BASE + {1'b0, r_i};
         default:   mem_addr = 8'h00;
      endcase
   end

   // Control sequence: three config loads, then read/write pairs per byte.
   always_ff @(posedge clk) begin
      if (init) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (!req) r_state <= S_LD_PRE;
            S_LD_PRE:  r_state <= S_LD_TAP;
            S_LD_TAP:  r_state <= S_LD_SEED;
            S_LD_SEED: r_state <= S_ENC_RD;
            S_ENC_RD:  r_state <= S_ENC_WR;
            S_ENC_WR:  r_state <= (r_i == L_LAST_IDX) ? S_DONE : S_ENC_RD;
            S_DONE:    if (req) r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   // Datapath registers: configuration latches, keystream, index, cipher byte.
   always_ff @(posedge clk) begin
      if (init) begin
         r_i    <= 7'd0;
         r_pre  <= 4'd0;
         r_taps <= 7'd0;
         r_lfsr <= 7'd0;
         r_c    <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE:    if (!req) r_i <= 7'd0;
            S_LD_PRE:  r_pre  <= mem_rdata[3:0];
            S_LD_TAP:  r_taps <= mem_rdata[6:0];
            S_LD_SEED: r_lfsr <= w_seed;
            S_ENC_RD:  r_c    <= {^w_cipher, w_cipher[6:0]};
            S_ENC_WR: begin
               r_lfsr <= w_lfsr_next;
               if (r_i != L_LAST_IDX) r_i <= r_i + 7'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// tb_lfsr_encrypt_engine
// Drives the encryptor against a split data memory (message/config below 64,
// cipher output 64..127) and compares every cipher byte against a byte-level
// model built from the padding, keystream and parity rules.

module tb_lfsr_encrypt_engine;

   logic       clk = 1'b0;
   logic       init;
   logic       req;
   logic       ack;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [7:0] mem_wdata;
   logic       mem_we;

   logic [7:0] msg_mem [0:63];
   logic [7:0] out_mem [0:63];
   logic [7:0] exp_c   [0:63];
   logic [7:0] saved_c [0:63];
   logic       clr_out = 1'b0;
   int         wr_count = 0;
   int         bad_wr = 0;
   int         passed = 0;
   int         total = 0;

   localparam string MSG1 = "Mr. Watson, come here. I want to see you.";

   lfsr_encrypt_engine dut (
      .clk       (clk),
      .init      (init),
      .req       (req),
      .ack       (ack),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we)
   );

   always #5 clk = ~clk;

   assign mem_rdata = (mem_addr[7:6] == 2'b00) ? msg_mem[mem_addr[5:0]] :
                      (mem_addr[7:6] == 2'b01) ? out_mem[mem_addr[5:0]] : 8'hFF;

   // Memory write port; anything outside 64..127 is tallied as a bad write.
   always @(posedge clk) begin
      if (clr_out) begin
         for (int j = 0; j < 64; j++) out_mem[j] <= 8'h00;
         wr_count <= 0;
         bad_wr   <= 0;
      end else if (mem_we) begin
         wr_count <= wr_count + 1;
         if (mem_addr[7:6] == 2'b01) out_mem[mem_addr[5:0]] <= mem_wdata;
         else bad_wr <= bad_wr + 1;
      end
   end

   // Reference model: build the padded 64-byte plaintext, then encrypt.
   function automatic void compute_expected();
      int pre;
      int taps;
      int lf;
      int p;
      int c;
      pre  = int'(msg_mem[61]) & 15;
      taps = int'(msg_mem[62]) & 127;
      lf   = int'(msg_mem[63]) & 127;
      if (lf == 0) lf = 1;
      for (int i = 0; i < 64; i++) begin
         if (i < pre) p = 32;
         else if (i - pre < 61) p = int'(msg_mem[i - pre]) & 127;
         else p = 32;
         c = (p ^ lf) & 127;
         if (($countones(c) % 2) == 1) c = c + 128;
         exp_c[i] = 8'(c);
         lf = ((lf * 2) + ($countones(lf & taps) % 2)) % 128;
      end
   endfunction

   // Keystream value used for byte idx, for the decrypt direction.
   function automatic int ks_at(input int seed, input int taps, input int idx);
      int lf;
      lf = seed & 127;
      if (lf == 0) lf = 1;
      for (int n = 0; n < idx; n++) lf = ((lf * 2) + ($countones(lf & taps) % 2)) % 128;
      return lf;
   endfunction

   task automatic load_text(input string s);
      for (int j = 0; j < 61; j++) msg_mem[j] = (j < s.len()) ? 8'(s[j]) : 8'h20;
   endtask

   task automatic load_random_text();
      for (int j = 0; j < 61; j++)
         msg_mem[j] = {1'($urandom_range(0, 1)), 7'($urandom_range(32, 126))};
   endtask

   task automatic set_cfg(input logic [7:0] pre_b, input logic [7:0] taps_b, input logic [7:0] seed_b);
      msg_mem[61] = pre_b;
      msg_mem[62] = taps_b;
      msg_mem[63] = seed_b;
   endtask

   task automatic clear_out();
      @(negedge clk);
      clr_out = 1'b1;
      @(negedge clk);
      clr_out = 1'b0;
   endtask

   // Start a run, return the edge index after which ack first rose (or -1),
   // then release with req=1 and report ack one edge later.
   task automatic run_engine(output int done_edge, output logic ack_after);
      @(negedge clk);
      req = 1'b0;
      done_edge = -1;
      for (int n = 0; n < 300; n++) begin
         @(posedge clk);
         #1;
         if (ack === 1'b1) begin
            done_edge = n;
            break;
         end
      end
      @(negedge clk);
      req = 1'b1;
      @(posedge clk);
      #1;
      ack_after = ack;
   endtask

   task automatic test_reset();
      @(negedge clk);
      init = 1'b1;
      req  = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if ({ack, mem_we, mem_addr, mem_wdata} !== 18'd0) begin
         $display("FAIL reset_outputs: got ack=%b we=%b addr=%h wdata=%h, expected all zero",
                  ack, mem_we, mem_addr, mem_wdata);
      end else passed++;
      @(posedge clk);
      #1;
      total++;
      if (mem_addr !== 8'h00 || ack !== 1'b0) begin
         $display("FAIL reset_beats_req: got addr=%h ack=%b, expected addr=00 ack=0", mem_addr, ack);
      end else passed++;
      @(negedge clk);
      req  = 1'b1;
      init = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (mem_addr !== 8'h00 || mem_we !== 1'b0) begin
         $display("FAIL idle_hold: got addr=%h we=%b, expected addr=00 we=0", mem_addr, mem_we);
      end else passed++;
      $display("reset: checks done");
   endtask

   task automatic test_basic();
      int   done_edge;
      logic ack_after;
      int   bad;
      load_text(MSG1);
      set_cfg(8'h0A, 8'h60, 8'h01);
      compute_expected();
      clear_out();
      run_engine(done_edge, ack_after);
      total++;
      if (done_edge != 131) $display("FAIL done_latency: got edge %0d expected 131", done_edge);
      else passed++;
      total++;
      if (ack_after !== 1'b0) $display("FAIL ack_release: got %b expected 0", ack_after);
      else passed++;
      total++;
      if (out_mem[0] !== 8'h21) $display("FAIL dm64: got %h expected 21", out_mem[0]);
      else passed++;
      total++;
      if (out_mem[1] !== 8'h22) $display("FAIL dm65: got %h expected 22", out_mem[1]);
      else passed++;
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         total++;
         if (out_mem[i] !== exp_c[i]) begin
            $display("FAIL basic_byte%0d: got %h expected %h", i, out_mem[i], exp_c[i]);
            bad++;
         end else passed++;
         saved_c[i] = out_mem[i];
      end
      total++;
      if (wr_count != 64 || bad_wr != 0) $display("FAIL basic_writes: got %0d writes %0d stray, expected 64 and 0", wr_count, bad_wr);
      else passed++;
      $display("basic: pre=10 taps=60 seed=01 done_edge=%0d mismatched_bytes=%0d", done_edge, bad);
   endtask

   task automatic test_seed_zero();
      int   done_edge;
      logic ack_after;
      int   bad;
      set_cfg(8'h0A, 8'h60, 8'h80);
      clear_out();
      run_engine(done_edge, ack_after);
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         total++;
         if (out_mem[i] !== saved_c[i]) begin
            $display("FAIL seed0_byte%0d: got %h expected %h", i, out_mem[i], saved_c[i]);
            bad++;
         end else passed++;
      end
      $display("seed_zero: seed byte 80 mismatched_bytes=%0d", bad);
   endtask

   task automatic test_pre15();
      int   done_edge;
      logic ack_after;
      int   bad;
      int   ks;
      load_text(MSG1);
      set_cfg(8'hFF, 8'h60, 8'h01);
      compute_expected();
      clear_out();
      run_engine(done_edge, ack_after);
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         total++;
         if (out_mem[i] !== exp_c[i]) begin
            $display("FAIL pre15_byte%0d: got %h expected %h", i, out_mem[i], exp_c[i]);
            bad++;
         end else passed++;
      end
      ks = ks_at(1, 8'h60, 15);
      total++;
      if ((int'(out_mem[15]) & 127) != (ks ^ 8'h4D))
         $display("FAIL pre15_first_char: got %h expected low bits %h", out_mem[15], ks ^ 8'h4D);
      else passed++;
      $display("pre15: mismatched_bytes=%0d", bad);
   endtask

   task automatic test_taps();
      logic [7:0] tap_list [0:8];
      int   done_edge;
      logic ack_after;
      int   bad;
      int   seed;
      int   pre;
      int   k;
      int   ks;
      tap_list = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};
      for (int t = 0; t < 9; t++) begin
         load_random_text();
         seed = int'($urandom_range(0, 255));
         pre  = (t == 0) ? 0 : int'($urandom_range(0, 15));
         set_cfg({4'($urandom_range(0, 15)), 4'(pre)}, {1'($urandom_range(0, 1)), tap_list[t][6:0]}, 8'(seed));
         compute_expected();
         clear_out();
         run_engine(done_edge, ack_after);
         bad = 0;
         for (int i = 0; i < 64; i++) begin
            total++;
            if (out_mem[i] !== exp_c[i]) begin
               $display("FAIL taps%h_byte%0d: got %h expected %h", tap_list[t], i, out_mem[i], exp_c[i]);
               bad++;
            end else passed++;
         end
         // Decrypt direction: parity must hold and the shifted message come back.
         for (int i = 0; i < 64; i++) begin
            ks = ks_at(seed, int'(tap_list[t]) & 127, i);
            k  = i - pre;
            total++;
            if (out_mem[i][7] !== ^out_mem[i][6:0]) begin
               $display("FAIL parity_byte%0d: got bit7=%b expected %b", i, out_mem[i][7], ^out_mem[i][6:0]);
               bad++;
            end else if (((int'(out_mem[i]) & 127) ^ ks) !=
                         ((k >= 0 && k < 61) ? (int'(msg_mem[k]) & 127) : 32)) begin
               $display("FAIL roundtrip_byte%0d: got %h expected %h", i,
                        (int'(out_mem[i]) & 127) ^ ks, (k >= 0 && k < 61) ? (int'(msg_mem[k]) & 127) : 32);
               bad++;
            end else passed++;
         end
         total++;
         if (done_edge != 131 || bad_wr != 0) $display("FAIL taps%h_run: got edge %0d stray %0d expected 131 and 0", tap_list[t], done_edge, bad_wr);
         else passed++;
         $display("taps=%h seed=%h pre=%0d mismatched_bytes=%0d", tap_list[t], seed, pre, bad);
      end
   endtask

   task automatic test_init_midrun();
      int   done_edge;
      logic ack_after;
      int   writes_at_reset;
      int   bad;
      load_random_text();
      set_cfg(8'h05, 8'h48, 8'h33);
      compute_expected();
      clear_out();
      @(negedge clk);
      req = 1'b0;
      for (int n = 0; n < 40; n++) @(posedge clk);
      @(negedge clk);
      init = 1'b1;
      req  = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (mem_we !== 1'b0 || ack !== 1'b0) $display("FAIL midrun_reset: got we=%b ack=%b expected 0 0", mem_we, ack);
      else passed++;
      writes_at_reset = wr_count;
      @(negedge clk);
      init = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (wr_count != writes_at_reset) $display("FAIL midrun_no_writes: got %0d writes expected %0d", wr_count, writes_at_reset);
      else passed++;
      clear_out();
      run_engine(done_edge, ack_after);
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         total++;
         if (out_mem[i] !== exp_c[i]) begin
            $display("FAIL rerun_byte%0d: got %h expected %h", i, out_mem[i], exp_c[i]);
            bad++;
         end else passed++;
      end
      total++;
      if (done_edge != 131) $display("FAIL rerun_latency: got edge %0d expected 131", done_edge);
      else passed++;
      $display("init_midrun: writes_before_reset=%0d rerun mismatched_bytes=%0d", writes_at_reset, bad);
   endtask

   initial begin
      init = 1'b1;
      req  = 1'b1;
      for (int j = 0; j < 64; j++) msg_mem[j] = 8'h20;
      test_reset();
      test_basic();
      test_seed_zero();
      test_pre15();
      test_taps();
      test_init_midrun();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
